// File: rtl/seg7_reader.sv
// ============================================================================
// seg7_reader: recovers the hex digit shown on an active-low 7-segment bus
// Optional feature macro: SEG7_READER_BLANK_EN (all-off pattern as blank)
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       seg,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       digit,
  output logic             err,
`ifdef SEG7_READER_BLANK_EN
  output logic             blank,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [6:0]       sample_q;
  logic [6:0]       last_q, last_d;
  logic [6:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       dec_digit;
  logic             dec_err;
`ifdef SEG7_READER_BLANK_EN
  logic             blank_q, blank_d;
  logic             dec_blank;
`endif

  // Classify the candidate pattern; unknown codes decode as digit 0 with err.
  always_comb begin
    dec_digit = 4'h0;
    dec_err   = 1'b0;
`ifdef SEG7_READER_BLANK_EN
    dec_blank = 1'b0;
`endif
    case (cand_q)
      7'h40: dec_digit = 4'h0;
      7'h79: dec_digit = 4'h1;
      7'h24: dec_digit = 4'h2;
      7'h30: dec_digit = 4'h3;
      7'h19: dec_digit = 4'h4;
      7'h12: dec_digit = 4'h5;
      7'h02: dec_digit = 4'h6;
      7'h78: dec_digit = 4'h7;
      7'h00: dec_digit = 4'h8;
      7'h10: dec_digit = 4'h9;
      7'h08: dec_digit = 4'hA;
      7'h03: dec_digit = 4'hB;
      7'h46: dec_digit = 4'hC;
      7'h21: dec_digit = 4'hD;
      7'h06: dec_digit = 4'hE;
      7'h0E: dec_digit = 4'hF;
`ifdef SEG7_READER_BLANK_EN
      7'h7F: dec_blank = 1'b1;
`endif
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    digit_d   = digit_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
`ifdef SEG7_READER_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (sample_q != last_q) begin
          state_d = SETTLE;
          cand_d  = sample_q;
          cnt_d   = C_ONE;
        end
      end
      SETTLE: begin
        // cnt_q counts matching samples already seen, so the entry cycle counts as one.
        if (cnt_q >= C_STABLE) begin
          state_d = EMIT;
          digit_d = dec_digit;
          err_d   = dec_err;
          last_d  = cand_q;
`ifdef SEG7_READER_BLANK_EN
          blank_d = dec_blank;
`endif
        end else if (sample_q == cand_q) begin
          cnt_d = cnt_q + C_ONE;
        end else begin
          cand_d = sample_q;
          cnt_d  = C_ONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = IDLE;
          if (err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + C_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sample_q  <= 7'h7F;
      last_q    <= 7'h7F;
      cand_q    <= 7'h7F;
      cnt_q     <= '0;
      digit_q   <= 4'h0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef SEG7_READER_BLANK_EN
      blank_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sample_q  <= seg;
      last_q    <= last_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef SEG7_READER_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign out_valid = (state_q == EMIT);
  assign digit     = digit_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
`ifdef SEG7_READER_BLANK_EN
  assign blank     = blank_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_reader.sv
// ============================================================================
// tb_seg7_reader: directed self-checking bench for seg7_reader
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_reader;

  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 2;

  logic       clk;
  logic       resetn;
  logic [6:0] seg;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] digit;
  logic       err;
  logic [7:0] err_cnt;
`ifdef SEG7_READER_BLANK_EN
  logic       blank;
`endif

  int total = 0;
  int bad   = 0;

  seg7_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .seg       (seg),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .digit     (digit),
    .err       (err),
`ifdef SEG7_READER_BLANK_EN
    .blank     (blank),
`endif
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Returns edges elapsed until out_valid is seen at a falling edge, bounded.
  task automatic wait_valid(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      step(1);
      cycles++;
      if (out_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    seg    = 7'h7F;
    step(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; seg = 7'h7F; out_ready = 1'b0;
    step(2);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (digit !== 4'h0) begin bad++; $display("FAIL reset_digit got=%0h want=0", digit); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_cnt); end
    resetn = 1'b1;
    step(3);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_7f_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_first_glyph();
    int cyc; bit ok; int extra;
    out_ready = 1'b1;
    seg = 7'h40;
    wait_valid(20, cyc, ok);
    total++; if (!ok || cyc != LAT) begin bad++; $display("FAIL first_latency got=%0d ok=%0b want=%0d", cyc, ok, LAT); end
    total++; if (digit !== 4'h0 || err !== 1'b0) begin bad++; $display("FAIL first_result got=%0h/%0b want=0/0", digit, err); end
    step(1);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid === 1'b1) extra++;
      step(1);
    end
    total++; if (extra != 0) begin bad++; $display("FAIL first_repeat got=%0d want=0", extra); end
  endtask

  task automatic test_sweep();
    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int cyc; bit ok;
    do_reset();
    out_ready = 1'b1;
    for (int g = 0; g < 16; g++) begin
      seg = glyphs[g];
      wait_valid(20, cyc, ok);
      total++;
      if (!ok || digit !== g[3:0] || err !== 1'b0) begin
        bad++; $display("FAIL sweep_%0d got=%0h err=%0b ok=%0b want=%0h err=0", g, digit, err, ok, g[3:0]);
      end
      step(4);
    end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL sweep_errcnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_glitch();
    int cyc; bit ok; int extra;
    out_ready = 1'b1;
    seg = 7'h79;
    step(2);
    seg = 7'h24;
    wait_valid(20, cyc, ok);
    total++; if (!ok || cyc != LAT) begin bad++; $display("FAIL glitch_latency got=%0d ok=%0b want=%0d", cyc, ok, LAT); end
    total++; if (digit !== 4'h2 || err !== 1'b0) begin bad++; $display("FAIL glitch_result got=%0h/%0b want=2/0", digit, err); end
    step(1);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid === 1'b1) extra++;
      step(1);
    end
    total++; if (extra != 0) begin bad++; $display("FAIL glitch_repeat got=%0d want=0", extra); end
  endtask

  task automatic test_backpressure();
    int cyc; bit ok; int held;
    out_ready = 1'b0;
    seg = 7'h7E;
    wait_valid(20, cyc, ok);
    total++; if (!ok || cyc != LAT) begin bad++; $display("FAIL bp_latency got=%0d ok=%0b want=%0d", cyc, ok, LAT); end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (out_valid === 1'b1) held++;
    end
    total++; if (held != 20) begin bad++; $display("FAIL bp_hold got=%0d want=20", held); end
    total++; if (digit !== 4'h0 || err !== 1'b1) begin bad++; $display("FAIL bp_result got=%0h/%0b want=0/1", digit, err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL bp_errcnt_pre got=%0d want=0", err_cnt); end
    out_ready = 1'b1;
    step(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%0b want=0", out_valid); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL bp_errcnt_post got=%0d want=1", err_cnt); end
  endtask

  task automatic test_emit_change();
    int cyc; bit ok;
    out_ready = 1'b0;
    seg = 7'h40;
    wait_valid(20, cyc, ok);
    seg = 7'h30;
    step(5);
    total++; if (!ok || out_valid !== 1'b1 || digit !== 4'h0) begin bad++; $display("FAIL emit_hold got=%0h v=%0b want=0 v=1", digit, out_valid); end
    out_ready = 1'b1;
    step(1);
    wait_valid(20, cyc, ok);
    total++; if (!ok || digit !== 4'h3 || err !== 1'b0) begin bad++; $display("FAIL emit_next got=%0h err=%0b ok=%0b want=3 err=0", digit, err, ok); end
    total++; if (cyc != STABLE + 1) begin bad++; $display("FAIL emit_next_latency got=%0d want=%0d", cyc, STABLE + 1); end
    step(3);
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok;
    out_ready = 1'b1;
    seg = 7'h19;
    step(3);
    #2 resetn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || digit !== 4'h0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_reset got=v%0b d%0h e%0b c%0d want=all 0", out_valid, digit, err, err_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    wait_valid(20, cyc, ok);
    total++; if (!ok || cyc != LAT || digit !== 4'h4) begin bad++; $display("FAIL mid_afresh got=%0h cyc=%0d want=4 cyc=%0d", digit, cyc, LAT); end
    step(3);
  endtask

  task automatic test_saturation();
    int cyc; bit ok; int missed;
    do_reset();
    out_ready = 1'b1;
    missed = 0;
    for (int i = 0; i < 260; i++) begin
      seg = i[0] ? 7'h7D : 7'h7E;
      wait_valid(20, cyc, ok);
      if (!ok) missed++;
      step(1);
      if (i == 253) begin
        total++; if (err_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", err_cnt); end
      end
    end
    total++; if (missed != 0) begin bad++; $display("FAIL sat_timeouts got=%0d want=0", missed); end
    total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%0d want=255", err_cnt); end
  endtask

  task automatic test_all_off();
    int cyc; bit ok; int extra;
    do_reset();
    out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (out_valid === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL off_after_reset got=%0d want=0", extra); end
    seg = 7'h00;
    wait_valid(20, cyc, ok);
    total++; if (!ok || digit !== 4'h8 || err !== 1'b0) begin bad++; $display("FAIL off_eight got=%0h err=%0b want=8 err=0", digit, err); end
    step(3);
    seg = 7'h7F;
    wait_valid(20, cyc, ok);
`ifdef SEG7_READER_BLANK_EN
    total++; if (!ok || blank !== 1'b1 || err !== 1'b0 || digit !== 4'h0) begin
      bad++; $display("FAIL off_blank got=b%0b e%0b d%0h want=b1 e0 d0", blank, err, digit);
    end
    step(1);
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL off_blank_cnt got=%0d want=0", err_cnt); end
`else
    total++; if (!ok || err !== 1'b1 || digit !== 4'h0) begin bad++; $display("FAIL off_err got=e%0b d%0h want=e1 d0", err, digit); end
    step(1);
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL off_err_cnt got=%0d want=1", err_cnt); end
`endif
  endtask

  initial begin
    seg = 7'h7F; out_ready = 1'b0; resetn = 1'b0;
    test_reset();
    test_first_glyph();
    test_sweep();
    test_glitch();
    test_backpressure();
    test_emit_change();
    test_reset_mid();
    test_saturation();
    test_all_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
